// File: rtl/dn491m_pkg.sv
// Shared definitions for the 491.52 MHz -> 245.76 MHz decimating FIR.
//
// Contents:
//   DW_DEFAULT / CW_DEFAULT : default sample and coefficient widths
//   ACC_MAX                 : working width used by the round/saturate helper
//   acc_width()             : accumulator width DW + CW + clog2(L), wide enough
//                             that the full L-tap sum never overflows
//   round_sat()             : round-half-up, arithmetic shift, then clamp to a
//                             signed dw-bit range (result returned at ACC_MAX
//                             width; the caller truncates to dw bits)
package dn491m_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int CW_DEFAULT = 16;
    localparam int ACC_MAX    = 64;

    localparam logic signed [ACC_MAX-1:0] ACC_ONE = 64'sd1;

    function automatic int acc_width(input int dw, input int cw, input int l);
        return dw + cw + $clog2(l);
    endfunction

    function automatic logic signed [ACC_MAX-1:0] round_sat(
        input logic signed [ACC_MAX-1:0] acc,
        input int                        shift,
        input int                        dw
    );
        logic signed [ACC_MAX-1:0] half;
        logic signed [ACC_MAX-1:0] r;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        half = (shift > 0) ? (ACC_ONE <<< (shift - 1)) : '0;
        r    = (acc + half) >>> shift;
        hi   = (ACC_ONE <<< (dw - 1)) - ACC_ONE;
        lo   = -(ACC_ONE <<< (dw - 1));
        if (r > hi) begin
            round_sat = hi;
        end else if (r < lo) begin
            round_sat = lo;
        end else begin
            round_sat = r;
        end
    endfunction

endpackage

// File: rtl/dn491m_to_245m_fir_tree_pipe.sv
// Registered product stage followed by a fully pipelined binary adder tree.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_vld     : launch strobe, aligned with the x/h contents to be summed
//   in_ca      : alignment tag travelling with in_vld
//   x          : L packed DW-bit signed samples, x[0] in the low bits
//   h          : L packed CW-bit signed coefficients, h[0] in the low bits
//   out_vld    : strobe, 1 + clog2(L) edges after in_vld
//   out_ca     : tag of the launch that produced out_vld
//   sum        : sum of h[k]*x[k], AW bits signed
//
// Tree storage is one flat node array: level j (0 = products) starts at
// 2L - 2*(L >> j) and holds L >> j nodes; the root is the last node.
module fir_tree_pipe
    import dn491m_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int CW = CW_DEFAULT,
    parameter int L  = 16,
    parameter int AW = acc_width(DW_DEFAULT, CW_DEFAULT, 16)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic                 in_ca,
    input  logic [L*DW-1:0]      x,
    input  logic [L*CW-1:0]      h,
    output logic                 out_vld,
    output logic                 out_ca,
    output logic signed [AW-1:0] sum
);

    localparam int LG    = $clog2(L);
    localparam int PW    = DW + CW;
    localparam int NODES = 2 * L - 1;

    function automatic int lvl_off(input int j);
        return 2 * L - 2 * (L >> j);
    endfunction

    logic signed [PW-1:0] prod [L];
    logic signed [AW-1:0] node [NODES];
    logic [LG:0]          vld_p;
    logic [LG:0]          ca_p;

    always_comb begin
        for (int k = 0; k < L; k++) begin
            prod[k] = PW'($signed(x[k*DW +: DW])) * PW'($signed(h[k*CW +: CW]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NODES; n++) begin
                node[n] <= '0;
            end
            vld_p <= '0;
            ca_p  <= '0;
        end else begin
            for (int k = 0; k < L; k++) begin
                node[k] <= AW'(prod[k]);
            end
            for (int j = 1; j <= LG; j++) begin
                for (int n = 0; n < (L >> j); n++) begin
                    node[lvl_off(j) + n] <= node[lvl_off(j - 1) + 2 * n]
                                          + node[lvl_off(j - 1) + 2 * n + 1];
                end
            end
            vld_p <= {vld_p[LG-1:0], in_vld};
            ca_p  <= {ca_p[LG-1:0], in_ca & in_vld};
        end
    end

    assign out_vld = vld_p[LG];
    assign out_ca  = ca_p[LG];
    assign sum     = node[NODES-1];

endmodule

// File: rtl/dn491m_to_245m.sv
// Receive-path 2:1 decimator: L-tap runtime-loadable FIR, keeping every
// second valid sample (phase 0), with ca re-alignment.
//
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_data_vld/_ca/i_data : input sample stream (ca meaningful when vld=1)
//   i_load_parameter   : one coefficient word per high cycle
//   i_parameter_data   : coefficient word, first word of a set is h[0]
//   o_data_vld/_ca/o_data : decimated output stream
//   o_param_done       : one-cycle pulse when a full set becomes active
//
// Stream semantics: vld is a pure strobe with no ready/backpressure; a
// sample is consumed on every edge where vld=1, and o_data_vld is a
// one-cycle strobe per output. o_data / o_data_ca hold between strobes.
// Latency from the edge that samples a phase-0 input (counted as edge 1) to
// the edge presenting the output is 3 + clog2(L).
module dn491m_to_245m
    import dn491m_pkg::*;
#(
    parameter int DW        = DW_DEFAULT,
    parameter int CW        = CW_DEFAULT,
    parameter int L         = 16,
    parameter int OUT_SHIFT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_data_vld,
    input  logic          i_data_ca,
    input  logic [DW-1:0] i_data,
    input  logic          i_load_parameter,
    input  logic [CW-1:0] i_parameter_data,
    output logic          o_data_vld,
    output logic          o_data_ca,
    output logic [DW-1:0] o_data,
    output logic          o_param_done
);

    localparam int LG = $clog2(L);
    localparam int AW = acc_width(DW, CW, L);

    logic [L*DW-1:0]      dline;
    logic                 ph;          // phase the next valid sample gets unless ca=1
    logic                 sample_ph;
    logic                 launch_vld;
    logic                 launch_ca;

    logic [L*CW-1:0]      shadow;
    logic [L*CW-1:0]      shadow_next;
    logic [L*CW-1:0]      active;
    logic [LG-1:0]        cnt;
    logic                 done;

    logic                 tree_vld;
    logic                 tree_ca;
    logic signed [AW-1:0] tree_sum;

    // ca=1 forces the sample onto phase 0 so the stream re-aligns to it.
    assign sample_ph = i_data_ca ? 1'b0 : ph;

    // Delay line and launch strobe. The launch is registered in the same
    // edge as the shift, so it lines up with the delay line contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dline      <= '0;
            ph         <= 1'b0;
            launch_vld <= 1'b0;
            launch_ca  <= 1'b0;
        end else begin
            launch_vld <= 1'b0;
            launch_ca  <= 1'b0;
            if (i_data_vld) begin
                dline      <= {dline[(L-1)*DW-1:0], i_data};
                ph         <= ~sample_ph;
                launch_vld <= ~sample_ph;
                launch_ca  <= i_data_ca;
            end
        end
    end

    // Words enter at the top of the shadow bank and move down, so after L
    // words the first one sits in h[0]. The active bank takes the completed
    // set (including the word arriving this edge) in one step.
    assign shadow_next = {i_parameter_data, shadow[L*CW-1:CW]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow <= '0;
            active <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (i_load_parameter) begin
                shadow <= shadow_next;
                if (cnt == LG'(L - 1)) begin
                    active <= shadow_next;
                    cnt    <= '0;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt + LG'(1);
                end
            end else begin
                // Strobe dropped before a full set: abandon the partial set.
                cnt <= '0;
            end
        end
    end

    // The active bank is read only at the product register, so each output
    // is computed from exactly one coefficient set.
    fir_tree_pipe #(
        .DW (DW),
        .CW (CW),
        .L  (L),
        .AW (AW)
    ) u_tree (
        .clk     (i_clk),
        .rst     (i_rst),
        .in_vld  (launch_vld),
        .in_ca   (launch_ca),
        .x       (dline),
        .h       (active),
        .out_vld (tree_vld),
        .out_ca  (tree_ca),
        .sum     (tree_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_vld <= 1'b0;
            o_data_ca  <= 1'b0;
            o_data     <= '0;
        end else begin
            o_data_vld <= tree_vld;
            if (tree_vld) begin
                o_data    <= DW'(round_sat(ACC_MAX'(tree_sum), OUT_SHIFT, DW));
                o_data_ca <= tree_ca;
            end
        end
    end

    assign o_param_done = done;

endmodule
